hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RV32I core. It takes decoded register usage from ID, destination, load, write-enable and redirect information from EX, and the data-memory request/ready handshake from MEM. From these it drives per-stage register enables and flushes. It inserts load-use bubbles, squashes wrong-path instructions on taken branches and jumps, freezes the whole pipeline while data memory is busy, and latches a fatal error if memory never answers.

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the five-stage RV32I core.
// Generates per-stage enables and flushes for load-use bubbles, redirect
// squashes and data-memory freezes, and latches a sticky error when memory
// stays busy longer than TIMEOUT cycles.
// Optional build macro: HAZARD_PERF_CNT_EN enables the stall/flush counters;
// without it the counter ports are tied to zero and no counter flops exist.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_we,
  input  logic        ex_load,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          busy, load_use, redirect_take;

  assign busy     = mem_req & ~mem_ready;
  assign load_use = ex_load & ex_we & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  // Redirect only acts when the pipeline is actually moving.
  assign redirect_take = rst_n & (state != S_ERR) & ~busy & ex_redirect;

  // Next-state and wait-counter logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_RUN: begin
        if (busy) begin
          state_nx = S_WAIT;
          cnt_nx   = ONE;
        end
      end
      S_WAIT: begin
        if (busy) begin
          if (TO_EN && (cnt == TO_V)) state_nx = S_ERR;
          else if (cnt != '1)         cnt_nx   = cnt + ONE;
        end else begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end
      end
      S_ERR:   state_nx = S_ERR;
      default: begin
        state_nx = S_RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RUN;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mem_err <= mem_err | (state_nx == S_ERR);
    end
  end

  // Stage enables and flushes, highest priority first; zero latency.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst_n || state == S_ERR || busy) begin
      // frozen: everything held
    end else if (ex_redirect) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters for stalled and redirected cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != 32'hFFFF_FFFF)       stall_cnt <= stall_cnt + 32'd1;
      if (redirect_take && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
  logic unused_perf;
  assign unused_perf = redirect_take;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a
// cycle-level behavioural model (consecutive-busy count, sticky error flag,
// integer perf counters).
module tb_hazard_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_we, ex_load, ex_redirect, mem_req, mem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // model state
  bit          m_err;
  int          m_run;
  logic [31:0] m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TO), .CW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  logic [71:0] dut_vec;
  assign dut_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, mem_err, stall_cnt, flush_cnt};

  // Expected enables/flushes straight from the priority rules.
  function automatic logic [6:0] exp_outs();
    bit busy, hz1, hz2, lu;
    busy = mem_req && !mem_ready;
    hz1  = id_use_rs1 && (id_rs1 == ex_rd);
    hz2  = id_use_rs2 && (id_rs2 == ex_rd);
    lu   = ex_load && ex_we && (ex_rd != 0) && (hz1 || hz2);
    if (!rst_n || m_err || busy) return 7'b0000000;
    if (ex_redirect)             return 7'b1111111;
    if (lu)                      return 7'b0011101;
    return 7'b1111100;
  endfunction

  function automatic logic [71:0] exp_vec();
`ifdef HAZARD_PERF_CNT_EN
    return {exp_outs(), m_err, m_stall, m_flush};
`else
    return {exp_outs(), m_err, 32'h0, 32'h0};
`endif
  endfunction

  // Model update at each clock edge / async reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err <= 1'b0; m_run <= 0; m_stall <= '0; m_flush <= '0;
    end else begin
      if (!exp_outs()[6] && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 1;
      if (!m_err && !(mem_req && !mem_ready) && ex_redirect) m_flush <= m_flush + 1;
      if (!m_err) begin
        if (mem_req && !mem_ready) begin
          if (TO != 0 && m_run + 1 == TO + 1) m_err <= 1'b1;
          m_run <= m_run + 1;
        end else m_run <= 0;
      end
    end
  end

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                       input logic [4:0] rd, input bit we, input bit ld, input bit rdr,
                       input bit req, input bit rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_we = we; ex_load = ld; ex_redirect = rdr;
    mem_req = req; mem_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 1, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec !== 72'h0) begin
      failures++; $display("FAIL reset_outputs got=%h want=%h", dut_vec, 72'h0);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec());
    end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    logic [6:0] exp_tab [4];
    exp_tab[0] = 7'b0011101; exp_tab[1] = 7'b1111100;
    exp_tab[2] = 7'b1111100; exp_tab[3] = 7'b1111100;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(5'd7, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0); // lw x5; add rs2=x5
        1: drive(5'd7, 5'd5, 1, 1, 5'd9, 1, 0, 0, 0, 0); // bubble in EX
        2: drive(5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0); // rd=x0
        default: drive(5'd7, 5'd5, 1, 0, 5'd5, 1, 1, 0, 0, 0); // rs2 unused
      endcase
      @(negedge clk);
      checks++;
      if (dut_vec[71:65] !== exp_tab[i]) begin
        failures++; $display("FAIL load_use[%0d] got=%b want=%b", i, dut_vec[71:65], exp_tab[i]);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL load_use_model[%0d] got=%h want=%h", i, dut_vec, exp_vec());
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] f0;
    f0 = flush_cnt;
    drive(5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0, 0); // redirect + load_use
    @(negedge clk);
    checks++;
    if (dut_vec[71:65] !== 7'b1111111) begin
      failures++; $display("FAIL redirect_vs_lu got=%b want=%b", dut_vec[71:65], 7'b1111111);
    end
    next_cycle();
    drive(5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
`ifdef HAZARD_PERF_CNT_EN
    if (flush_cnt !== f0 + 32'd1) begin
      failures++; $display("FAIL redirect_flush_cnt got=%0d want=%0d", flush_cnt, f0 + 32'd1);
    end
`else
    if (flush_cnt !== 32'h0) begin
      failures++; $display("FAIL redirect_flush_cnt got=%0d want=0", flush_cnt);
    end
`endif
    next_cycle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 1, (i < 4), (i == 3));
      if (i == 4) ex_redirect = 1'b0;
      @(negedge clk);
      checks++;
      if (dut_vec[71:65] !== ((i < 3) ? 7'b0000000 : (i == 3) ? 7'b1111111 : 7'b1111100)) begin
        failures++; $display("FAIL mem_wait[%0d] got=%b", i, dut_vec[71:65]);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL mem_wait_model[%0d] got=%h want=%h", i, dut_vec, exp_vec());
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      drive(5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 1, (c >= 8));
      @(negedge clk);
      checks++;
      if (mem_err !== (c >= 6)) begin
        failures++; $display("FAIL timeout_err[c%0d] got=%b want=%b", c, mem_err, (c >= 6));
      end
      checks++;
      if (dut_vec[71:65] !== 7'b0) begin
        failures++; $display("FAIL timeout_enables[c%0d] got=%b want=0", c, dut_vec[71:65]);
      end
      next_cycle();
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (mem_err !== 1'b0) begin
      failures++; $display("FAIL err_reset got=%b want=0", mem_err);
    end
    next_cycle();
    rst_n = 1'b1;
    drive(5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (dut_vec[71:64] !== 8'b11111000) begin
      failures++; $display("FAIL err_to_run got=%b want=11111000", dut_vec[71:64]);
    end
    next_cycle();
  endtask

  task automatic test_stall_count();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      // 4 load-use cycles, run, 3 busy, ready, 3 busy, ready
      case (i)
        0, 1, 2, 3: drive(5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0, 0);
        4:          drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        5, 6, 7:    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        8:          drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1);
        9, 10, 11:  drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        default:    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
      endcase
      next_cycle();
    end
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
`ifdef HAZARD_PERF_CNT_EN
    if (stall_cnt !== 32'd10) begin
      failures++; $display("FAIL stall_cnt got=%0d want=10", stall_cnt);
    end
`else
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL perf_tied got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
`endif
    next_cycle();
  endtask

  task automatic test_random();
    int nfail = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) == 0), 1'($urandom));
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        if (nfail++ < 10) $display("FAIL random[%0d] got=%h want=%h", i, dut_vec, exp_vec());
      end
      next_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_stall_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
